// File: rtl/whack_judge.sv
// Whack-a-mole judge: hit/miss decisions, BCD score, miss count and game-over FSM.
// Optional countdown timer enabled by defining WAM_TIMER_EN.
module whack_judge #(
    parameter int MAX_MISSES   = 5,
    parameter int GAME_SECONDS = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       pulse,
    input  logic [4:0] molePositions,
    input  logic [4:0] moleButtonPulses,
    output logic       hitAck,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic [7:0] timeLeft,
    output logic       gameOver
);

    typedef enum logic [2:0] {IDLE, WAIT_MOLE, ARMED, HIT, OVER} state_t;

    localparam logic [4:0] MAX5     = 5'(MAX_MISSES);
    localparam logic [3:0] MAX4     = 4'(MAX_MISSES);
    localparam logic [7:0] GAME_BCD = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};

    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t     state;
    logic [4:0] btnPrev;
    logic [4:0] pressP0;
    logic [4:0] moleP0;
    logic       moleChgP0;

    // Stage 0: edge detect on buttons, registered mole and mole-change flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btnPrev   <= '0;
            pressP0   <= '0;
            moleP0    <= '0;
            moleChgP0 <= 1'b0;
        end else begin
            btnPrev   <= moleButtonPulses;
            pressP0   <= moleButtonPulses & ~btnPrev;
            moleP0    <= molePositions;
            moleChgP0 <= (molePositions != moleP0);
        end
    end

    logic       playing;
    logic       wrongPress;
    logic       hitEvent;
    logic       missEvent;
    logic [4:0] missInc;
    logic [3:0] missNext;
    logic       missEnd;
    logic       timeEnd;
    logic       endGame;
    state_t     armNext;

`ifdef WAM_TIMER_EN
    function automatic logic [7:0] bcdDec(input logic [7:0] v);
        if (v == 8'h00)
            return v;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic       pulsePrev;
    logic       tickP0;
    logic [7:0] timeReg;
    logic [7:0] timeNext;
    logic       tickEvent;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pulsePrev <= 1'b0;
            tickP0    <= 1'b0;
        end else begin
            pulsePrev <= pulse;
            tickP0    <= pulse & ~pulsePrev;
        end
    end

    assign tickEvent = playing && tickP0;
    assign timeNext  = bcdDec(timeReg);
    assign timeEnd   = tickEvent && (timeNext == 8'h00);
    assign timeLeft  = timeReg;
`else
    // Constant zero; pulse and GAME_SECONDS are referenced so the disabled build still consumes them.
    assign timeEnd  = 1'b0;
    assign timeLeft = {8{pulse}} & GAME_BCD & 8'h00;
`endif

    always_comb begin
        playing    = enable && (state == WAIT_MOLE || state == ARMED || state == HIT);
        wrongPress = |(pressP0 & ~moleP0);
        hitEvent   = playing && (state == ARMED) && !moleChgP0 &&
                     (pressP0 != 5'd0) && (pressP0 == moleP0);
        missEvent  = playing &&
                     (((state == WAIT_MOLE) && (moleP0 == 5'd0) && (pressP0 != 5'd0)) ||
                      ((state == ARMED) && (moleChgP0 || wrongPress)));
        missInc    = {1'b0, misses} + 5'd1;
        missNext   = (missInc >= MAX5) ? MAX4 : missInc[3:0];
        missEnd    = missEvent && (missInc >= MAX5);
        endGame    = missEnd || timeEnd;
        armNext    = (moleP0 != 5'd0) ? ARMED : WAIT_MOLE;
    end

    // Stage 1: game FSM with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hitAck   <= 1'b0;
            score    <= 8'h00;
            misses   <= 4'd0;
            gameOver <= 1'b0;
`ifdef WAM_TIMER_EN
            timeReg  <= 8'h00;
`endif
        end else begin
            hitAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= WAIT_MOLE;
                        score  <= 8'h00;
                        misses <= 4'd0;
`ifdef WAM_TIMER_EN
                        timeReg <= GAME_BCD;
`endif
                    end
                end
                WAIT_MOLE, ARMED, HIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        if (hitEvent) begin
                            score  <= bcdInc(score);
                            hitAck <= 1'b1;
                        end
                        if (missEvent)
                            misses <= missNext;
`ifdef WAM_TIMER_EN
                        if (tickEvent)
                            timeReg <= timeNext;
`endif
                        if (endGame) begin
                            state    <= OVER;
                            gameOver <= 1'b1;
                        end else begin
                            case (state)
                                WAIT_MOLE: if (moleP0 != 5'd0) state <= ARMED;
                                ARMED: begin
                                    if (moleChgP0)
                                        state <= armNext;
                                    else if (hitEvent)
                                        state <= HIT;
                                    else if (moleP0 == 5'd0)
                                        state <= WAIT_MOLE;
                                end
                                HIT: if (moleChgP0) state <= armNext;
                                default: state <= state;
                            endcase
                        end
                    end
                end
                OVER: begin
                    if (!enable) begin
                        state    <= IDLE;
                        gameOver <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_whack_judge.sv
// Directed bench for whack_judge: reset, hits, misses, BCD saturation, game over, timer.
module tb_whack_judge;

    localparam int GAME_S = 3;
`ifdef WAM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       pulse = 1'b0;
    logic [4:0] molePositions = 5'd0;
    logic [4:0] moleButtonPulses = 5'd0;
    logic       hitAck;
    logic [7:0] score;
    logic [3:0] misses;
    logic [7:0] timeLeft;
    logic       gameOver;

    int         nCompared = 0;
    int         nMismatched = 0;
    logic [4:0] curMole;
    logic       lastAck;

    always #5 clock = ~clock;

    whack_judge #(.MAX_MISSES(5), .GAME_SECONDS(GAME_S)) dut (
        .clock(clock), .reset(reset), .enable(enable), .pulse(pulse),
        .molePositions(molePositions), .moleButtonPulses(moleButtonPulses),
        .hitAck(hitAck), .score(score), .misses(misses),
        .timeLeft(timeLeft), .gameOver(gameOver)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // press then release; afterwards the FSM has reacted to the press
    task automatic press(input logic [4:0] b);
        moleButtonPulses = b;
        tick(1);
        moleButtonPulses = 5'd0;
        tick(1);
    endtask

    task automatic setMole(input logic [4:0] m);
        molePositions = m;
        tick(2);
    endtask

    task automatic pulseOnce();
        pulse = 1'b1;
        tick(1);
        pulse = 1'b0;
        tick(1);
    endtask

    task automatic doHit();
        press(curMole);
        lastAck = hitAck;
        curMole = {curMole[3:0], curMole[4]};
        setMole(curMole);
    endtask

    initial begin
        #3;
        checkVal("rst_hitAck", hitAck, 0);
        checkVal("rst_score", score, 8'h00);
        checkVal("rst_misses", misses, 0);
        checkVal("rst_gameOver", gameOver, 0);
        checkVal("rst_timeLeft", timeLeft, 8'h00);
        #20 reset = 1'b1;
        tick(1);

        // idle: presses change nothing
        molePositions = 5'b00100;
        press(5'b00100);
        checkVal("idle_score", score, 8'h00);
        checkVal("idle_misses", misses, 0);
        checkVal("idle_hitAck", hitAck, 0);

        // first hit with a held button
        enable = 1'b1;
        tick(2);
        moleButtonPulses = 5'b00100;
        tick(2);
        checkVal("hit_ack", hitAck, 1);
        checkVal("hit_score", score, 8'h01);
        tick(1);
        checkVal("hit_ack_onecycle", hitAck, 0);
        tick(2);
        checkVal("held_score", score, 8'h01);
        moleButtonPulses = 5'd0;
        tick(1);
        press(5'b00100);
        checkVal("repress_score", score, 8'h01);
        checkVal("repress_ack", hitAck, 0);
        tick(1);

        // wrong press and escape
        setMole(5'b00001);
        checkVal("moleChg_after_hit_misses", misses, 0);
        press(5'b01000);
        checkVal("wrong_misses", misses, 1);
        setMole(5'b10000);
        checkVal("escape_misses", misses, 2);
        press(5'b10001);
        checkVal("mixed_misses", misses, 3);
        checkVal("mixed_score", score, 8'h01);

        // BCD counting and saturation
        curMole = 5'b10000;
        repeat (8) doHit();
        checkVal("bcd_09", score, 8'h09);
        doHit();
        checkVal("bcd_10", score, 8'h10);
        repeat (89) doHit();
        checkVal("bcd_99", score, 8'h99);
        doHit();
        checkVal("sat_score", score, 8'h99);
        checkVal("sat_ack", lastAck, 1);
        checkVal("sat_misses", misses, 3);

        // game over on fifth miss
        press({curMole[3:0], curMole[4]});
        checkVal("miss4", misses, 4);
        checkVal("miss4_over", gameOver, 0);
        press({curMole[3:0], curMole[4]});
        checkVal("miss5", misses, 5);
        checkVal("miss5_over", gameOver, 1);
        press(curMole);
        checkVal("over_ack", hitAck, 0);
        press({curMole[3:0], curMole[4]});
        checkVal("over_misses_frozen", misses, 5);
        enable = 1'b0;
        tick(1);
        checkVal("idle_over_clear", gameOver, 0);
        checkVal("idle_score_hold", score, 8'h99);
        checkVal("idle_misses_hold", misses, 5);
        enable = 1'b1;
        tick(1);
        checkVal("restart_score", score, 8'h00);
        checkVal("restart_misses", misses, 0);
        checkVal("restart_time", timeLeft, TIMER ? 8'h03 : 8'h00);
        tick(1);

        // escape to empty mole, then press while waiting
        setMole(5'b00000);
        checkVal("escape_zero_misses", misses, 1);
        press(5'b00010);
        checkVal("wait_press_misses", misses, 2);
        setMole(5'b00100);
        press(5'b00100);
        checkVal("rearm_ack", hitAck, 1);
        checkVal("rearm_score", score, 8'h01);

        // timer tick, then reset mid-countdown
        pulseOnce();
        checkVal("time_first", timeLeft, TIMER ? 8'h02 : 8'h00);
        reset = 1'b0;
        #2;
        checkVal("midrst_score", score, 8'h00);
        checkVal("midrst_misses", misses, 0);
        checkVal("midrst_time", timeLeft, 8'h00);
        checkVal("midrst_over", gameOver, 0);
        reset = 1'b1;
        tick(3);
        checkVal("timer_load", timeLeft, TIMER ? 8'h03 : 8'h00);
        pulseOnce();
        checkVal("timer_02", timeLeft, TIMER ? 8'h02 : 8'h00);
        pulseOnce();
        checkVal("timer_01", timeLeft, TIMER ? 8'h01 : 8'h00);
        checkVal("timer_01_over", gameOver, 0);
        pulseOnce();
        checkVal("timer_00", timeLeft, 8'h00);
        checkVal("timer_over", gameOver, TIMER ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/whack_judge.md
# whack_judge

Judging and scoring engine for the whack-a-mole game: the consumer of the mole generator's positions and the debounced mole buttons. It decides hit vs. miss for each mole and keeps a two-digit BCD score and a miss count. It ends the game on too many misses or, optionally, on time-out, and returns a one-cycle hit acknowledge so the generator can retire a struck mole early. It sits between the debouncers and mole generator on one side and the segment display on the other.

## Interface
- MAX_MISSES, 5: miss count that ends the game (1–15).
- GAME_SECONDS, 60: game length in `pulse` ticks (used only with WAM_TIMER_EN; 1–99).
- clock  input  1  100 MHz system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- enable  input  1  game running request (level).
- pulse  input  1  1 Hz increment tick, sampled in the `clock` domain; rising edge counts as one tick.
- molePositions  input  5  one-hot (or zero) active mole from the generator.
- moleButtonPulses  input  5  debounced mole buttons.
- hitAck  output  1  one-cycle pulse on a counted hit.
- score  output  8  BCD {tens, ones}, 0–99.
- misses  output  4  binary miss count.
- timeLeft  output  8  BCD seconds remaining.
- gameOver  output  1  high in OVER state.

## Operation
- Button input: registered copy per bit; a press = rising edge (bit high now, low in previous cycle). Held buttons count once.
- Mole change: `molePositions` differs from its registered previous value.
- FSM states and transitions:
  - IDLE → WAIT_MOLE when enable=1. Entering from IDLE clears score, misses, timer (timeLeft=GAME_SECONDS).
  - WAIT_MOLE (molePositions==0) → ARMED when molePositions≠0.
  - ARMED: correct press (press vector == molePositions' set bit, no other bits) → HIT, score+1, hitAck. Any press containing a bit not in molePositions → miss+1, stay ARMED. Mole change with no hit → escape miss+1, then ARMED (new nonzero mole) or WAIT_MOLE (zero).
  - HIT: further presses ignored; on mole change → ARMED or WAIT_MOLE, no miss.
  - WAIT_MOLE: any press → miss+1.
  - Any state except OVER: misses reaching MAX_MISSES → OVER.
  - OVER: outputs frozen, presses ignored; exits only when enable=0 → IDLE.
  - enable=0 in any playing state → IDLE; score/misses hold their values.
- Presses in a mole-change cycle are ignored; only the escape rule applies.
- Mixed correct+wrong bits in one cycle = miss, no hit.
- Score: BCD increment, ones 9→0 carries into tens. Score saturates at 99, and hitAck still pulses at saturation.
- Misses saturate at MAX_MISSES.

## Timing
- Reset values: hitAck=0, score=8'h00, misses=0, gameOver=0, timeLeft=8'h00, state IDLE.
- Latency: an input edge present before rising edge K updates score, misses, hitAck and state at edge K+1. This is one registered stage after the edge-detect register.
- hitAck is high for exactly one clock.
- gameOver asserts in the same cycle the final miss is registered.
- Reset mid-game returns everything to reset values immediately (asynchronous assertion).
- Reset deassertion is synchronous in effect: the first active edge after release starts normal operation.

## Configuration
- WAM_TIMER_EN defined:
  - each `pulse` rising edge in WAIT_MOLE, ARMED or HIT decrements timeLeft (BCD).
  - At 00 the FSM goes to OVER on the same edge. If a hit or miss occurs on that edge, the score/miss update is still applied.
- WAM_TIMER_EN undefined:
  - timer logic is absent and timeLeft is tied to 8'h00.
  - the game ends only on MAX_MISSES.
  - `pulse` is unused.

## Test plan
- Reset and idle: reset low, then high with enable=0 → all outputs 0; presses change nothing.
- Hit counting: enable=1, molePositions=5'b00100, press bit 2 → hitAck for 1 cycle, score=8'h01. Hold the button, re-press while the mole is unchanged → score stays 01.
- Wrong press and escape: mole 5'b00001, press bit 3 → misses=1. Mole changes to 5'b10000 without a hit → misses=2. Press 5'b10001 → misses=3, score unchanged.
- BCD and saturation: 9 hits → score=8'h09, 10th hit → 8'h10. Run 99 hits then one more → score=8'h99 and hitAck pulses.
- Game over: MAX_MISSES=5, five wrong presses → gameOver=1 on the fifth. Later correct presses are ignored. enable=0 → IDLE; enable=1 → score and misses cleared.
- Timer, with WAM_TIMER_EN and GAME_SECONDS=3:
  - three pulse ticks → timeLeft 03→02→01→00, gameOver=1.
  - with the macro undefined, timeLeft stays 00 and gameOver stays 0.
  - assert reset mid-countdown → all outputs 0 at once.
